// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle core with an external request/valid fetch port, run/halt control and a retire counter.
// Min 2 cycles/instruction, each fetch wait cycle adds one. Optional trace port under CPU_MC_TRACE_EN.
module cpu_mc #(
  parameter  int DATA_W  = 16,
  parameter  int NREGS   = 8,
  parameter  int PC_W    = 8,
  localparam int RI_W    = $clog2(NREGS),
  localparam int INSTR_W = 4 + 3*RI_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    run,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic [INSTR_W-1:0]      imem_rdata,
  input  logic                    imem_valid,
  output logic [PC_W-1:0]         pc,
  output logic                    halted,
  output logic [NREGS*DATA_W-1:0] reg_state,
  output logic [31:0]             retired
`ifdef CPU_MC_TRACE_EN
  ,
  output logic                    trace_valid,
  output logic [PC_W-1:0]         trace_pc,
  output logic [INSTR_W-1:0]      trace_instr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [31:0]          retired_q, retired_d;
  logic [DATA_W-1:0]    regs_q [NREGS];
  logic                 wr_en;
  logic [DATA_W-1:0]    wr_val;

  logic [3:0]           op;
  logic [RI_W-1:0]      rs, rt, rd;
  logic [DATA_W-1:0]    opa, opb, imm_d;
  logic [PC_W-1:0]      imm_pc;

  assign op     = ir_q[INSTR_W-1 -: 4];
  assign rs     = ir_q[3*RI_W-1 -: RI_W];
  assign rt     = ir_q[2*RI_W-1 -: RI_W];
  assign rd     = ir_q[RI_W-1:0];
  assign opa    = regs_q[rs];
  assign opb    = regs_q[rt];
  // The rs field doubles as the signed immediate for ADDI and BEQZ.
  assign imm_d  = {{(DATA_W-RI_W){rs[RI_W-1]}}, rs};
  assign imm_pc = {{(PC_W-RI_W){rs[RI_W-1]}}, rs};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    wr_en     = 1'b0;
    wr_val    = '0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: if (imem_valid) begin
        ir_d    = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        retired_d = retired_q + 32'd1;
        pc_d      = pc_q + PC_W'(1);
        state_d   = S_FETCH;
        case (op)
          4'd1:  begin wr_en = 1'b1; wr_val = opa + opb;   end
          4'd2:  begin wr_en = 1'b1; wr_val = opa - opb;   end
          4'd3:  begin wr_en = 1'b1; wr_val = opa & opb;   end
          4'd4:  begin wr_en = 1'b1; wr_val = opa | opb;   end
          4'd5:  begin wr_en = 1'b1; wr_val = opa ^ opb;   end
          4'd6:  begin wr_en = 1'b1; wr_val = imm_d + opb; end
          4'd7:  if (opb == '0) pc_d = pc_q + PC_W'(1) + imm_pc;
          4'd15: begin pc_d = pc_q; state_d = S_HALT; end
          default: ;
        endcase
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      if (wr_en) regs_q[rd] <= wr_val;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;

  always_comb begin
    reg_state = '0;
    for (int i = 0; i < NREGS; i++) reg_state[i*DATA_W +: DATA_W] = regs_q[i];
  end

`ifdef CPU_MC_TRACE_EN
  assign trace_valid = (state_q == S_EXEC);
  assign trace_pc    = trace_valid ? pc_q : '0;
  assign trace_instr = trace_valid ? ir_q : '0;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: variable-latency instruction memory, instruction-level reference model and scoreboard.
`timescale 1ns/1ps
module tb_cpu_mc;
  localparam int DATA_W  = 16;
  localparam int NREGS   = 8;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 13;

  logic                    CLK = 1'b0;
  logic                    RST_N = 1'b0;
  logic                    run = 1'b0;
  logic                    imem_valid = 1'b0;
  logic [INSTR_W-1:0]      imem_rdata = '0;
  logic                    imem_req, halted;
  logic [PC_W-1:0]         imem_addr, pc;
  logic [NREGS*DATA_W-1:0] reg_state;
  logic [31:0]             retired;
`ifdef CPU_MC_TRACE_EN
  logic                    trace_valid;
  logic [PC_W-1:0]         trace_pc;
  logic [INSTR_W-1:0]      trace_instr;
`endif

  cpu_mc #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .pc(pc), .halted(halted), .reg_state(reg_state), .retired(retired)
`ifdef CPU_MC_TRACE_EN
    , .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PC_W-1:0]         pc;
    logic [NREGS*DATA_W-1:0] regs;
    logic [31:0]             ret;
    logic                    hlt;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [INSTR_W-1:0]   mem [256];
  int                   mem_wait = 0;
  bit                   mem_en = 0;
  bit                   pulse_req = 0;
  logic [DATA_W-1:0]    m_regs [NREGS];
  logic [PC_W-1:0]      m_pc;
  logic [31:0]          m_ret;
  exp_t                 sb_q [$];
  logic [PC_W+INSTR_W-1:0] tq [$];
  int                   t_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] enc(input int op, input int rs, input int rt, input int rd);
    logic [3:0] o; logic [2:0] s, t, d;
    o = op[3:0]; s = rs[2:0]; t = rt[2:0]; d = rd[2:0];
    return {o, s, t, d};
  endfunction

  function automatic logic [NREGS*DATA_W-1:0] flat();
    logic [NREGS*DATA_W-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*DATA_W +: DATA_W] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_pc = '0; m_ret = '0; t_cnt = 0;
    sb_q.delete(); tq.delete();
  endtask

  // Reference execution of one fetched instruction; the expected architectural state is queued.
  task automatic model_exec(input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] addr);
    logic [3:0] op; logic [2:0] rs, rt, rd;
    logic [DATA_W-1:0] a, b, imm; logic [PC_W-1:0] immp, npc;
    exp_t e; logic hlt;
    chk("fetch_addr", addr, m_pc);
    op = ins[12:9]; rs = ins[8:6]; rt = ins[5:3]; rd = ins[2:0];
    a = m_regs[rs]; b = m_regs[rt];
    imm = {{13{rs[2]}}, rs}; immp = {{5{rs[2]}}, rs};
    npc = m_pc + 8'd1; hlt = 1'b0;
    case (op)
      4'd1: m_regs[rd] = a + b;
      4'd2: m_regs[rd] = a - b;
      4'd3: m_regs[rd] = a & b;
      4'd4: m_regs[rd] = a | b;
      4'd5: m_regs[rd] = a ^ b;
      4'd6: m_regs[rd] = imm + b;
      4'd7: if (b == 16'd0) npc = m_pc + 8'd1 + immp;
      4'd15: begin hlt = 1'b1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc; m_ret = m_ret + 32'd1;
    e.pc = m_pc; e.regs = flat(); e.ret = m_ret; e.hlt = hlt;
    sb_q.push_back(e);
    tq.push_back({addr, ins});
  endtask

  // Memory responder and scoreboard monitor, all on the falling edge.
  initial begin
    int wcnt; logic [PC_W-1:0] held; logic req_prev, halt_prev; exp_t e;
    logic [PC_W+INSTR_W-1:0] tr;
    wcnt = 0; held = '0; req_prev = 0; halt_prev = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        imem_valid = 0; wcnt = 0; req_prev = 0; halt_prev = 0;
      end else begin
        if ((imem_req && !req_prev) || (halted && !halt_prev)) begin
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_regs", reg_state, e.regs);
            chk("sb_retired", retired, e.ret);
            chk("sb_halted", halted, e.hlt);
          end
        end
        req_prev = imem_req; halt_prev = halted;
`ifdef CPU_MC_TRACE_EN
        if (trace_valid) begin
          t_cnt++;
          if (tq.size() > 0) begin
            tr = tq.pop_front();
            chk("trace_pc", trace_pc, tr[PC_W+INSTR_W-1:INSTR_W]);
            chk("trace_instr", trace_instr, tr[INSTR_W-1:0]);
          end else chk("trace_spurious", 1, 0);
        end
`endif
        if (imem_valid) begin
          imem_valid = 0; wcnt = 0;
        end else if (pulse_req) begin
          imem_rdata = enc(6, 3, 1, 1); imem_valid = 1; pulse_req = 0;
        end else if (mem_en && imem_req) begin
          if (wcnt == 0) held = imem_addr;
          else chk("addr_stable", imem_addr, held);
          if (wcnt == mem_wait) begin
            imem_rdata = mem[imem_addr]; imem_valid = 1;
            model_exec(mem[imem_addr], imem_addr);
          end else wcnt++;
        end
      end
    end
  end

  task automatic do_reset();
    RST_N = 0; run = 0; mem_en = 0; pulse_req = 0;
    repeat (2) @(negedge CLK);
    model_reset();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    RST_N = 1;
    @(negedge CLK);
  endtask

  task automatic run_prog(input int w, input int k);
    int n; logic [PC_W-1:0] pcs;
    mem_wait = w; mem_en = 1; run = 1; n = 0;
    while (!halted && n < 2000) begin @(negedge CLK); n++; end
    chk("halt_reached", halted, 1);
    chk("cycles", n, k*(w+2)+1);
    pcs = pc;
    repeat (4) @(negedge CLK);
    chk("halt_pc_frozen", pc, pcs);
    chk("halt_req", imem_req, 0);
    chk("halt_retired", retired, k);
    chk("sb_drained", sb_q.size(), 0);
`ifdef CPU_MC_TRACE_EN
    chk("trace_count", t_cnt, k);
`endif
    mem_en = 0;
  endtask

  task automatic load_p2();
    mem[0] = enc(6, 1, 1, 1);
    mem[1] = enc(1, 1, 1, 2);
    mem[2] = enc(2, 1, 2, 3);
    mem[3] = enc(15, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_regs", reg_state, 0);

    mem[0] = enc(6, 3, 1, 1); mem[1] = enc(15, 0, 0, 0);
    run_prog(0, 2);
    chk("p1_r1", reg_state[31:16], 16'd3);
    chk("p1_pc", pc, 1);
    chk("p1_retired", retired, 2);

    do_reset(); load_p2();
    run_prog(0, 4);
    chk("p2_r2", reg_state[47:32], 16'd2);
    chk("p2_r3", reg_state[63:48], 16'hFFFF);

    do_reset(); load_p2();
    run_prog(3, 4);
    chk("p2w_r2", reg_state[47:32], 16'd2);
    chk("p2w_r3", reg_state[63:48], 16'hFFFF);

    do_reset();
    mem[0] = enc(6, 3, 1, 1);  mem[1] = enc(6, -4, 2, 2); mem[2] = enc(1, 1, 1, 1);
    mem[3] = enc(3, 1, 2, 3);  mem[4] = enc(4, 1, 2, 4);  mem[5] = enc(5, 4, 1, 5);
    mem[6] = enc(9, 7, 7, 7);  mem[7] = enc(2, 0, 1, 6);  mem[8] = enc(15, 0, 0, 0);
    run_prog(1, 9);
    chk("p3_double", reg_state[31:16], 16'd6);
    chk("p3_xor", reg_state[95:80], 16'hFFF8);
    chk("p3_nop9", reg_state[127:112], 16'd0);

    do_reset();
    mem[1] = enc(7, 3, 0, 0); mem[5] = enc(7, -2, 0, 0);
    mem[4] = enc(6, 3, 0, 0); mem[6] = enc(15, 0, 0, 0);
    run_prog(0, 6);
    chk("p4_pc", pc, 6);

    do_reset();
    mem[0] = enc(7, -3, 1, 0); mem[254] = enc(6, 1, 1, 1); mem[1] = enc(15, 0, 0, 0);
    run_prog(2, 5);
    chk("p5_pc", pc, 1);
    chk("p5_r1", reg_state[31:16], 16'd1);

    do_reset(); load_p2();
    mem_wait = 20; mem_en = 1; run = 1;
    repeat (4) @(negedge CLK);
    chk("mid_fetch_req", imem_req, 1);
    #2 RST_N = 0; run = 0; mem_en = 0;
    #1 chk("async_rst_req", imem_req, 0);
    @(negedge CLK);
    RST_N = 1; model_reset(); pulse_req = 1;
    repeat (4) @(negedge CLK);
    chk("post_rst_req", imem_req, 0);
    chk("post_rst_pc", pc, 0);
    chk("post_rst_regs", reg_state, 0);
    chk("post_rst_retired", retired, 0);
    chk("post_rst_halted", halted, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle core.
- Instruction memory moves outside the core, behind a request/valid fetch port with variable latency.
- Core adds run/halt control, a conditional branch, and a retired-instruction counter.
- Datapath width, register count and PC width are all generic; it sits between the testbench/top level and an external instruction memory.

Parameters:
DATA_W, 16, register and ALU width
NREGS, 8, number of general registers (power of two, >=4)
PC_W, 8, program counter width; address space 2**PC_W words
(derived) RI_W = $clog2(NREGS); INSTR_W = 4 + 3*RI_W

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
run  in  1  start execution from IDLE
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_rdata  in  INSTR_W  fetched instruction
imem_valid  in  1  imem_rdata valid this cycle
pc  out  PC_W  current program counter
halted  out  1  core in HALT state
reg_state  out  NREGS*DATA_W  flattened register file, reg i at [i*DATA_W +: DATA_W]
retired  out  32  count of executed instructions

Behaviour:
- Reset is asynchronous and active-low on RST_N; single clock CLK.
- Reset values: state=IDLE, pc=0, all registers 0, retired=0, imem_req=0, halted=0.
- Reset mid-fetch or mid-exec returns to IDLE immediately; any later imem_valid is ignored.
- Instruction format, MSB to LSB: op[4] | rs[RI_W] | rt[RI_W] | rd[RI_W].
- imm is the rs field sign-extended to DATA_W (ADDI) or PC_W (BEQZ).
- Opcodes:
  - 0 NOP
  - 1 ADD: rd=rs+rt
  - 2 SUB: rd=rs-rt
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI: rd=imm+rt
  - 7 BEQZ: if reg[rt]==0 then pc=pc+1+imm, else pc+1; no register write
  - 15 HALT
  - 8-14 execute as NOP
- Arithmetic wraps modulo 2**DATA_W; pc arithmetic wraps modulo 2**PC_W.
- No register is hardwired to zero.
- FSM:
  - IDLE: imem_req=0. run=1 -> FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_valid=1. On that edge, latch imem_rdata into the instruction register -> EXEC. imem_valid while imem_req=0 is ignored. At most one request outstanding.
  - EXEC: one cycle. Read operands, write rd (ALU ops and ADDI only), update pc, retired+=1.
    - Next state: HALT if op==15, else FETCH.
    - HALT still counts as retired; pc stays at the HALT address.
  - HALT: halted=1, imem_req=0, pc/registers frozen. run is ignored; only RST_N exits.
- Latency: minimum 2 cycles per instruction (response in first FETCH cycle + EXEC). Each wait cycle adds one.
- Operand read and writeback in the same EXEC cycle: sources read the pre-write value, e.g. ADD r1,r1,r1 doubles r1.
- retired wraps at 2**32.
- BEQZ with imm = -1 branches to itself (legal infinite loop).
- run held high continuously has no effect outside IDLE.

Optional Feature:
- Macro: CPU_MC_TRACE_EN.
- Defined:
  - Adds outputs trace_valid (1), trace_pc (PC_W) and trace_instr (INSTR_W).
  - trace_valid=1 exactly during each EXEC cycle, carrying that instruction's pc and encoding; all three are 0 otherwise and at reset.
- Undefined: these ports and their logic do not exist.
- Core behaviour is identical either way.

Test Plan:
- Reset then run=1; memory returns ADDI r1,r1,3 (r1=0) with zero wait, then HALT -> r1=3, pc=1, retired=2, halted=1, imem_req=0.
- Program ADDI r1,+1; ADD r2,r1,r1; SUB r3,r1,r2; HALT with DATA_W=16 -> r2=2, r3=0xFFFF, retired=4.
- Memory delays imem_valid 3 cycles per fetch -> imem_addr stable while imem_req=1; 5 cycles per instruction; results match the zero-wait run.
- BEQZ r0, imm=-2 at pc=5 with r0=0 -> next fetch address 4. With r0=7 -> next fetch address 6. pc=2**PC_W-1 with NOP -> next fetch 0.
- Assert RST_N low while in FETCH, release, then pulse imem_valid without run -> stays IDLE, pc=0, registers 0, retired=0.
- With CPU_MC_TRACE_EN: 3-instruction program -> exactly 3 trace_valid pulses, trace_pc = 0, 1, 2.
